// File: rtl/fib_pkg.sv
// Shared encodings and seed constants for the Fibonacci/Lucas sequence engine.
package fib_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic MODE_FIB = 1'b0;
    localparam logic MODE_LUC = 1'b1;

    localparam int unsigned FIB_S0 = 0;
    localparam int unsigned FIB_S1 = 1;
    localparam int unsigned LUC_S0 = 2;
    localparam int unsigned LUC_S1 = 1;

    function automatic int unsigned seed0(input logic mode);
        return (mode == MODE_FIB) ? FIB_S0 : LUC_S0;
    endfunction

    function automatic int unsigned seed1(input logic mode);
        return (mode == MODE_LUC) ? LUC_S1 : FIB_S1;
    endfunction

endpackage

// File: rtl/fib_seq_dp.sv
// Datapath for the sequence engine: term pair a/b, iteration counter and
// sticky per-register overflow tracking.
module fib_seq_dp
    import fib_pkg::*;
#(
    parameter int unsigned W  = 32,
    parameter int unsigned NW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          step,
    input  logic          mode,
    input  logic [NW-1:0] n,
    output logic [W-1:0]  b,
    output logic          b_ovf,
    output logic          last
);

    logic [W-1:0]  a;
    logic          a_ovf;
    logic [NW-1:0] cnt;
    logic [W:0]    sum;

    always_comb begin
        sum = {1'b0, a} + {1'b0, b};
    end

    // The exit compare is on 1 rather than 0 so the full index range never wraps cnt.
    assign last = (cnt == NW'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            a     <= '0;
            b     <= '0;
            cnt   <= '0;
            a_ovf <= 1'b0;
            b_ovf <= 1'b0;
        end else if (load) begin
            a     <= W'(seed0(mode));
            b     <= W'(seed1(mode));
            cnt   <= n;
            a_ovf <= 1'b0;
            b_ovf <= 1'b0;
        end else if (step) begin
            a     <= b;
            b     <= sum[W-1:0];
            cnt   <= cnt - NW'(1);
            a_ovf <= b_ovf;
            b_ovf <= a_ovf | b_ovf | sum[W];
        end
    end

endmodule

// File: rtl/fib_seq_engine.sv
// Fibonacci/Lucas term engine: control FSM, result registers and status decode
// around the fib_seq_dp datapath.
module fib_seq_engine
    import fib_pkg::*;
#(
    parameter int unsigned W  = 32,
    parameter int unsigned NW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          st,
    input  logic          mode,
    input  logic [NW-1:0] n,
    output logic [W-1:0]  fn,
    output logic          ovf,
    output logic          busy,
    output logic          done
);

    state_t       state;
    logic         load;
    logic         step;
    logic         last;
    logic [W-1:0] b;
    logic         b_ovf;

    always_comb begin
        load = 1'b0;
        step = 1'b0;
        case (state)
            CALC:    step = 1'b1;
            DONE:    ;
            default: load = st;
        endcase
    end

    fib_seq_dp #(
        .W  (W),
        .NW (NW)
    ) u_dp (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .step  (step),
        .mode  (mode),
        .n     (n),
        .b     (b),
        .b_ovf (b_ovf),
        .last  (last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            fn    <= '0;
            ovf   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                CALC: begin
                    busy <= 1'b1;
                    if (last) begin
                        fn    <= b;
                        ovf   <= b_ovf;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    // Unused encodings behave as IDLE.
                    busy  <= st;
                    done  <= 1'b0;
                    state <= IDLE;
                    if (st) begin
                        if (n == '0) begin
                            fn    <= W'(seed0(mode));
                            ovf   <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fib_seq_engine.sv
// Scoreboarded directed bench for fib_seq_engine at W=32 and W=8.
module tb_fib_seq_engine;

    typedef struct {
        logic [31:0] fn;
        logic        ovf;
        int unsigned lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        st32 = 1'b0, mode32 = 1'b0;
    logic [7:0]  n32 = '0;
    logic [31:0] fn32;
    logic        ovf32, busy32, done32;
    logic        st8 = 1'b0, mode8 = 1'b0;
    logic [7:0]  n8 = '0;
    logic [7:0]  fn8;
    logic        ovf8, busy8, done8;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    fib_seq_engine #(.W(32), .NW(8)) dut32 (
        .clk(clk), .rst(rst), .st(st32), .mode(mode32), .n(n32),
        .fn(fn32), .ovf(ovf32), .busy(busy32), .done(done32)
    );

    fib_seq_engine #(.W(8), .NW(8)) dut8 (
        .clk(clk), .rst(rst), .st(st8), .mode(mode8), .n(n8),
        .fn(fn8), .ovf(ovf8), .busy(busy8), .done(done8)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Independent reference: low W bits by modular addition, overflow by a
    // saturating exact value (sequence is nondecreasing past the seeds).
    function automatic void model(input int unsigned w, input bit m, input int unsigned nn,
                                  output logic [31:0] f, output logic o);
        longint unsigned cap  = 64'd1 << w;
        longint unsigned mask = cap - 1;
        longint unsigned am = m ? 2 : 0, bm = 1, as = m ? 2 : 0, bs = 1, t;
        for (int unsigned k = 0; k < nn; k++) begin
            t  = (am + bm) & mask; am = bm; bm = t;
            t  = as + bs; if (t > cap) t = cap; as = bs; bs = t;
        end
        f = am[31:0];
        o = (as >= cap);
    endfunction

    task automatic push(input logic [31:0] efn, input logic eovf, input int unsigned nn);
        exp_t e;
        e.fn = efn; e.ovf = eovf; e.lat = nn + 1;
        sb.push_back(e);
    endtask

    task automatic start(input bit nar, input bit m, input int unsigned nn,
                         input logic [31:0] efn, input logic eovf);
        @(negedge clk);
        if (nar) begin st8 = 1'b1; mode8 = m; n8 = nn[7:0]; end
        else     begin st32 = 1'b1; mode32 = m; n32 = nn[7:0]; end
        push(efn, eovf, nn);
    endtask

    task automatic start_model(input bit nar, input bit m, input int unsigned nn);
        logic [31:0] f;
        logic        o;
        model(nar ? 8 : 32, m, nn, f, o);
        start(nar, m, nn, f, o);
    endtask

    task automatic wait_done(input bit nar, input string tag, input bit hold, input bit poke);
        int unsigned cyc = 0;
        bit          busy_ok = 1'b1;
        logic        d;
        logic [31:0] f;
        exp_t        e;
        do begin
            @(negedge clk);
            cyc++;
            if (!hold) begin
                if (nar) st8 = 1'b0; else st32 = 1'b0;
            end
            if (poke && cyc == 3) begin st32 = 1'b1; n32 = 8'd3; mode32 = 1'b1; end
            d = nar ? done8 : done32;
            if (d !== 1'b1 && (nar ? busy8 : busy32) !== 1'b1) busy_ok = 1'b0;
        end while (d !== 1'b1 && cyc < 400);
        chk({tag, "_done_seen"}, d, 1'b1);
        if (sb.size() == 0) begin
            chk({tag, "_sb_nonempty"}, 0, 1);
        end else begin
            e = sb.pop_front();
            f = nar ? {24'd0, fn8} : fn32;
            chk({tag, "_latency"}, cyc, e.lat);
            chk({tag, "_fn"}, f, e.fn);
            chk({tag, "_ovf"}, nar ? ovf8 : ovf32, e.ovf);
            chk({tag, "_busy_held"}, busy_ok, 1'b1);
            @(negedge clk);
            chk({tag, "_done_pulse"}, nar ? done8 : done32, 1'b0);
            chk({tag, "_fn_stable"}, nar ? {24'd0, fn8} : fn32, e.fn);
            if (!hold) chk({tag, "_idle_busy"}, nar ? busy8 : busy32, 1'b0);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_fn32", fn32, 0);
        chk("rst_ovf32", ovf32, 0);
        chk("rst_busy32", busy32, 0);
        chk("rst_done32", done32, 0);
        chk("rst_fn8", fn8, 0);
        chk("rst_busy8", busy8, 0);
        rst = 1'b0;

        start(0, 0, 10, 32'd55, 1'b0);          wait_done(0, "fib10", 0, 0);
        start(0, 0, 0, 32'd0, 1'b0);            wait_done(0, "fib0", 0, 0);
        start(0, 1, 0, 32'd2, 1'b0);            wait_done(0, "luc0", 0, 0);
        start(0, 1, 10, 32'd123, 1'b0);         wait_done(0, "luc10", 0, 0);
        start(0, 0, 47, 32'd2971215073, 1'b0);  wait_done(0, "fib47", 0, 0);
        start(0, 0, 48, 32'd512559680, 1'b1);   wait_done(0, "fib48", 0, 0);
        start(0, 0, 1, 32'd1, 1'b0);            wait_done(0, "fib1", 0, 0);
        start(1, 0, 13, 32'd233, 1'b0);         wait_done(1, "w8_fib13", 0, 0);
        start(1, 0, 14, 32'd121, 1'b1);         wait_done(1, "w8_fib14", 0, 0);
        start_model(1, 0, 255);                 wait_done(1, "w8_fib255", 0, 0);
        start_model(1, 1, 255);                 wait_done(1, "w8_luc255", 0, 0);
        start_model(0, 1, 200);                 wait_done(0, "luc200", 0, 0);

        start(0, 0, 10, 32'd55, 1'b0);          wait_done(0, "busy_ignore", 0, 1);
        st32 = 1'b0;

        start(0, 0, 20, 32'd6765, 1'b0);
        repeat (5) begin @(negedge clk); st32 = 1'b0; end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        void'(sb.pop_back());
        chk("abort_fn", fn32, 0);
        chk("abort_ovf", ovf32, 0);
        chk("abort_busy", busy32, 0);
        chk("abort_done", done32, 0);
        start(0, 0, 5, 32'd5, 1'b0);            wait_done(0, "after_rst", 0, 0);

        start(0, 0, 4, 32'd3, 1'b0);
        push(32'd3, 1'b0, 4);
        push(32'd3, 1'b0, 4);
        wait_done(0, "b2b_0", 1, 0);
        wait_done(0, "b2b_1", 1, 0);
        wait_done(0, "b2b_2", 1, 0);
        st32 = 1'b0;
        repeat (2) @(negedge clk);
        chk("b2b_stop_busy", busy32, 0);
        chk("sb_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
